dff_input_debouncer: RTL and testbench

//  Conditions a raw, asynchronous, possibly bouncing level (switch/button) into a clean

---
 rtl/debounce_pkg.sv | 18 +
 rtl/dff_input_debouncer_if.sv | 20 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/dff_input_debouncer.sv | 113 +++++++++++
 tb/tb_dff_input_debouncer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer slice.
//   state_e   : debouncer FSM states (2-bit, fixed encodings)
//   cnt_width : stability counter width for a given STABLE_CYCLES
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW   = 2'b00,
        ST_ARM_H = 2'b01,
        ST_ARM_L = 2'b10,
        ST_HIGH  = 2'b11
    } state_e;

    // One extra bit over $clog2 so STABLE_CYCLES-1 always fits with headroom.
    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        return $clog2(stable_cycles) + 1;
    endfunction

endpackage

// File: rtl/dff_input_debouncer_if.sv
// Signal bundle between the debouncer and its user.
//   tick : sample qualifier (master -> slave)
//   d_in : raw asynchronous level (master -> slave)
//   q    : debounced level (slave -> master)
//   rise : one-cycle strobe when q becomes 1
//   fall : one-cycle strobe when q becomes 0
//   busy : a candidate level change is being qualified
interface dff_input_debouncer_if;
    logic tick;
    logic d_in;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    modport master (output tick, output d_in,
                    input  q, input rise, input fall, input busy);
    modport slave  (input  tick, input d_in,
                    output q, output rise, output fall, output busy);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk : sampling clock
//   rst : asynchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output (two clk edges of latency)
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/dff_input_debouncer.sv
// Debounces a raw switch/button level into a clean synchronous level.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : slave side of dff_input_debouncer_if (tick, d_in in; q, rise, fall, busy out)
// A new level is accepted only after the synchronized input has held it for
// STABLE_CYCLES consecutive tick-qualified samples; any reversion restarts.
module dff_input_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dff_input_debouncer_if.slave  bus
);

    localparam int unsigned      CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s2;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.d_in),
        .q   (s2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Strobes default low every edge so they last exactly one cycle,
    // including when the following edge is not tick-qualified.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (bus.tick) begin
            case (state_q)
                ST_LOW: begin
                    if (s2) begin
                        state_d = ST_ARM_H;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_ARM_H: begin
                    if (!s2) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_HIGH;
                        q_d     = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!s2) begin
                        state_d = ST_ARM_L;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_ARM_L: begin
                    if (s2) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_LOW;
                        q_d     = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    q_d     = 1'b0;
                end
            endcase
        end
    end

    assign bus.q    = q_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    assign bus.busy = (state_q == ST_ARM_H) || (state_q == ST_ARM_L);

endmodule

// File: tb/tb_dff_input_debouncer.sv
// Self-checking bench for dff_input_debouncer (STABLE_CYCLES = 4).
// Directed scenarios check fixed timings; a randomized bouncing-input run is
// checked against a run-length reference model.
module tb_dff_input_debouncer;

    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    dff_input_debouncer_if bus ();

    dff_input_debouncer #(.STABLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: input delayed by two edges, then the accepted level
    // flips once SC consecutive qualified samples disagree with it.
    logic m_s1, m_s2, m_q, m_rise, m_fall;
    int   m_run;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_q <= 1'b0;
            m_rise <= 1'b0; m_fall <= 1'b0; m_run <= 0;
        end else begin
            m_s1   <= bus.d_in;
            m_s2   <= m_s1;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (bus.tick) begin
                if (m_s2 != m_q) begin
                    if (m_run + 1 == SC) begin
                        m_q    <= m_s2;
                        m_rise <= m_s2;
                        m_fall <= !m_s2;
                        m_run  <= 0;
                    end else begin
                        m_run <= m_run + 1;
                    end
                end else begin
                    m_run <= 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_low();
        bus.tick = 1'b1;
        bus.d_in = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_reset();
        logic [3:0] got;
        bus.tick = 1'b1;
        bus.d_in = 1'b1;
        repeat (10) step();
        #2 rst = 1'b1;
        #1 got = {bus.q, bus.rise, bus.fall, bus.busy};
        n_cmp++;
        if (got !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_async: got q/rise/fall/busy=%b expected 0000", got);
        end
        @(negedge clk);
        bus.d_in = 1'b0;
        rst = 1'b0;
        repeat (4) step();
        got = {bus.q, bus.rise, bus.fall, bus.busy};
        n_cmp++;
        if (got !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_idle: got q/rise/fall/busy=%b expected 0000", got);
        end
    endtask

    task automatic test_rise_latency();
        logic [3:0] got, exp;
        idle_low();
        bus.d_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            got = {bus.q, bus.rise, bus.fall, bus.busy};
            exp = {i >= 5, i == 5, 1'b0, (i >= 2) && (i < 5)};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL rise_latency k+%0d: got q/rise/fall/busy=%b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] got, exp;
        idle_low();
        bus.d_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 2) bus.d_in = 1'b0;
            got = {bus.q, bus.rise, bus.fall, bus.busy};
            exp = {1'b0, 1'b0, 1'b0, (i >= 2) && (i <= 4)};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL glitch k+%0d: got q/rise/fall/busy=%b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_fall();
        logic [3:0] got, exp;
        idle_low();
        bus.d_in = 1'b1;
        repeat (10) step();
        bus.d_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            got = {bus.q, bus.rise, bus.fall, bus.busy};
            exp = {i < 5, 1'b0, i == 5, (i >= 2) && (i < 5)};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL fall k+%0d: got q/rise/fall/busy=%b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_tick_gating();
        logic [3:0] got, exp;
        idle_low();
        bus.d_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.tick = (i % 2 == 0);
            step();
            got = {bus.q, bus.rise, bus.fall, bus.busy};
            exp = {i >= 8, i == 8, 1'b0, (i >= 2) && (i < 8)};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL tick_gating k+%0d: got q/rise/fall/busy=%b expected %b", i, got, exp);
            end
        end
        bus.tick = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [3:0] got, exp;
        idle_low();
        bus.d_in = 1'b1;
        repeat (4) step();
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_busy: got busy=%b expected 1", bus.busy);
        end
        #2 rst = 1'b1;
        #1 got = {bus.q, bus.rise, bus.fall, bus.busy};
        n_cmp++;
        if (got !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_mid_async: got q/rise/fall/busy=%b expected 0000", got);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            got = {bus.q, bus.rise, bus.fall, bus.busy};
            exp = {i >= 5, i == 5, 1'b0, (i >= 2) && (i < 5)};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL reset_mid_release k+%0d: got q/rise/fall/busy=%b expected %b", i, got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] got, exp;
        int hold = 0;
        logic level = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
                level = 1'($urandom_range(0, 1));
                hold  = $urandom_range(1, 9);
            end
            hold--;
            bus.d_in = level;
            bus.tick = ($urandom_range(0, 3) != 0);
            step();
            got = {bus.q, bus.rise, bus.fall, bus.busy};
            exp = {m_q, m_rise, m_fall, m_run != 0};
            n_cmp++;
            if (got !== exp || (bus.rise && bus.fall)) begin
                n_bad++;
                $display("FAIL random cycle %0d: got q/rise/fall/busy=%b expected %b", i, got, exp);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        bus.tick = 1'b1;
        bus.d_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_rise_latency();
        test_glitch();
        test_fall();
        test_tick_gating();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
